mod3_stream_gen: RTL and testbench



---
 rtl/mod3_stream_gen.sv | 121 ++++++++++++
 tb/tb_mod3_stream_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod3_stream_gen.sv
// Serial stimulus source for the mod-3 ones-detector path: emits 3*groups ones
// separated by a programmable zero gap and flags the third one of every group.
module mod3_stream_gen #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] groups,
    input  logic [GAP_W-1:0] gap,
    output logic             dout,
    output logic             busy,
    output logic             group_end,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        ONE,
        GAP,
        DONE
    } state_t;

    state_t           state;
    logic [GAP_W-1:0] gap_r;
    logic [GAP_W-1:0] gap_cnt;
    logic [1:0]       phase;
    logic [CNT_W-1:0] remaining;

    // Outputs are loaded with the values of the state being entered, so phase
    // always names the position of the upcoming (or current) one in its group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gap_r     <= '0;
            gap_cnt   <= '0;
            phase     <= '0;
            remaining <= '0;
            dout      <= 1'b0;
            busy      <= 1'b0;
            group_end <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dout      <= 1'b0;
                    busy      <= 1'b0;
                    group_end <= 1'b0;
                    done      <= 1'b0;
                    if (start) begin
                        if (groups != '0) begin
                            gap_r     <= gap;
                            remaining <= groups;
                            phase     <= '0;
                            gap_cnt   <= '0;
                            state     <= ONE;
                            dout      <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                ONE: begin
                    if (phase == 2'd2) begin
                        remaining <= remaining - CNT_W'(1);
                        phase     <= '0;
                    end else begin
                        phase <= phase + 2'd1;
                    end

                    // No gap follows the final one of the transfer.
                    if (phase == 2'd2 && remaining == CNT_W'(1)) begin
                        state     <= DONE;
                        dout      <= 1'b0;
                        busy      <= 1'b0;
                        group_end <= 1'b0;
                        done      <= 1'b1;
                    end else if (gap_r != '0) begin
                        state     <= GAP;
                        gap_cnt   <= '0;
                        dout      <= 1'b0;
                        group_end <= 1'b0;
                    end else begin
                        state     <= ONE;
                        dout      <= 1'b1;
                        group_end <= (phase == 2'd1);
                    end
                end

                GAP: begin
                    if (gap_cnt == gap_r - GAP_W'(1)) begin
                        gap_cnt   <= '0;
                        state     <= ONE;
                        dout      <= 1'b1;
                        group_end <= (phase == 2'd2);
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    dout      <= 1'b0;
                    busy      <= 1'b0;
                    group_end <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod3_stream_gen.sv
// Scoreboard bench for mod3_stream_gen: directed transfers push expected per-cycle
// outputs into a queue that a negedge monitor drains whenever busy or done is high.
module tb_mod3_stream_gen;

    localparam int CNT_W = 8;
    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] groups = '0;
    logic [GAP_W-1:0] gap = '0;
    logic             dout;
    logic             busy;
    logic             group_end;
    logic             done;

    typedef struct {
        int   cycle;
        logic dout;
        logic busy;
        logic groupEnd;
        logic done;
    } exp_item_t;

    exp_item_t expQ[$];
    bit        oneSet[int];
    bit        geSet[int];
    int        errors = 0;
    int        checks = 0;
    string     curTest = "reset";

    mod3_stream_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .groups    (groups),
        .gap       (gap),
        .dout      (dout),
        .busy      (busy),
        .group_end (group_end),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic expDout, input logic expBusy,
                               input logic expGe, input logic expDone);
        checks++;
        if ({dout, busy, group_end, done} !== {expDout, expBusy, expGe, expDone}) begin
            errors++;
            $display("[TB] FAIL %s: dout/busy/group_end/done got %b%b%b%b, required %b%b%b%b",
                     name, dout, busy, group_end, done, expDout, expBusy, expGe, expDone);
        end
    endtask

    // Monitor: every cycle the DUT presents busy or done consumes one expected entry.
    always @(negedge clk) begin
        exp_item_t e;
        if (rst_n === 1'b1) begin
            if (busy || done) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL %s unexpected output: dout/busy/group_end/done got %b%b%b%b, required none",
                             curTest, dout, busy, group_end, done);
                end else begin
                    e = expQ.pop_front();
                    checkOutput($sformatf("%s cycle %0d", curTest, e.cycle),
                                e.dout, e.busy, e.groupEnd, e.done);
                end
            end else if (dout || group_end) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s stray output: dout/group_end got %b%b while idle, required 00",
                         curTest, dout, group_end);
            end
        end
    end

    task automatic markOnes(input int first, input int step, input int count);
        for (int k = 0; k < count; k++) oneSet[first + k * step] = 1'b1;
    endtask

    task automatic buildExpected(input int lastCycle, input int doneCycle);
        exp_item_t e;
        for (int c = 1; c <= lastCycle; c++) begin
            e.cycle    = c;
            e.dout     = (oneSet.exists(c) != 0);
            e.busy     = (c < doneCycle);
            e.groupEnd = (geSet.exists(c) != 0);
            e.done     = (c == doneCycle);
            expQ.push_back(e);
        end
        oneSet.delete();
        geSet.delete();
    endtask

    // Drives start for cycle 0 and returns #1 into cycle 1.
    task automatic applyStimulus(input string name, input int g, input int gp,
                                 input int lastCycle, input int doneCycle);
        @(posedge clk);
        #1;
        curTest = name;
        start   = 1'b1;
        groups  = g[CNT_W-1:0];
        gap     = gp[GAP_W-1:0];
        buildExpected(lastCycle, doneCycle);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDrain(input int maxCycles);
        int n = 0;
        while (expQ.size() != 0 && n < maxCycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: %0d expected cycles outstanding, required 0",
                     curTest, expQ.size());
            expQ.delete();
        end
        @(negedge clk);
        checkOutput({curTest, " idle after"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset held with start asserted: nothing may move.
        start  = 1'b1;
        groups = 8'd1;
        gap    = 4'd0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset hold", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        curTest = "post-reset g1 gap0";
        markOnes(1, 1, 3);
        geSet[3] = 1'b1;
        buildExpected(4, 4);
        @(negedge clk);
        checkOutput("release cycle", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDrain(20);

        markOnes(1, 1, 3);
        geSet[3] = 1'b1;
        applyStimulus("g1 gap0", 1, 0, 4, 4);
        waitDrain(20);

        markOnes(1, 3, 6);
        geSet[7]  = 1'b1;
        geSet[16] = 1'b1;
        applyStimulus("g2 gap2", 2, 2, 17, 17);
        waitDrain(40);

        applyStimulus("g0 gap5", 0, 5, 1, 1);
        waitDrain(10);

        markOnes(1, 2, 9);
        geSet[5]  = 1'b1;
        geSet[11] = 1'b1;
        geSet[17] = 1'b1;
        applyStimulus("g3 gap1 ignore", 3, 1, 18, 18);
        repeat (3) @(posedge clk);
        #1;
        start  = 1'b1;
        groups = 8'd7;
        gap    = 4'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDrain(40);

        // Abort: reset lands in cycle 6 (a gap cycle) of a 4-group transfer.
        markOnes(1, 2, 3);
        geSet[5] = 1'b1;
        applyStimulus("g4 gap1 abort", 4, 1, 5, 24);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("abort pre-reset", 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort async clear", 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL abort queue: %0d cycles unseen, required 0", expQ.size());
            expQ.delete();
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        curTest = "after abort";
        repeat (30) @(posedge clk);

        markOnes(1, 1, 3);
        geSet[3] = 1'b1;
        applyStimulus("restart g1 gap0", 1, 0, 4, 4);
        waitDrain(20);

        // Largest request: 255 groups with the widest gap.
        markOnes(1, 16, 765);
        for (int j = 0; j < 255; j++) geSet[1 + (3 * j + 2) * 16] = 1'b1;
        applyStimulus("g255 gap15", 255, 15, 12226, 12226);
        waitDrain(13000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
